// File: rtl/w5500_sock_rx_pkg.sv
// Shared constants for the W5500 socket receive sequencer: register offsets,
// control-byte encodings, block-select helpers and the sequencer state type.
package w5500_pkg;

  localparam logic [15:0] SN_CR     = 16'h0001;
  localparam logic [15:0] SN_RX_RSR = 16'h0026;
  localparam logic [15:0] SN_RX_RD  = 16'h0028;

  localparam logic [7:0]  CR_RECV   = 8'h40;

  localparam logic        RWB_READ  = 1'b0;
  localparam logic        RWB_WRITE = 1'b1;
  localparam logic [1:0]  OM_VDM    = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RSR1,
    ST_RSR2,
    ST_GAP,
    ST_PTR,
    ST_DATA,
    ST_WPTR,
    ST_WCMD
  } state_t;

  // Socket n register block and RX buffer block select codes.
  function automatic logic [4:0] bsb_reg(input int unsigned sock);
    return 5'(sock * 4 + 1);
  endfunction

  function automatic logic [4:0] bsb_rxb(input int unsigned sock);
    return 5'(sock * 4 + 3);
  endfunction

  function automatic logic [7:0] mk_cmd(input logic [4:0] bsb, input logic rwb);
    return {bsb, rwb, OM_VDM};
  endfunction

endpackage

// File: rtl/w5500_sock_rx_if.sv
// Request port between a W5500 sequencer (master) and spi_drv (slave).
interface w5500_sock_rx_if;
  logic        o_start;
  logic [7:0]  o_cmd;
  logic [15:0] o_addr;
  logic [15:0] o_length;
  logic [7:0]  o_dat;
  logic        i_dat_req;
  logic        i_dat_vld;
  logic [7:0]  i_dat;
  logic        i_wr_end;

  modport master (
    output o_start, o_cmd, o_addr, o_length, o_dat,
    input  i_dat_req, i_dat_vld, i_dat, i_wr_end
  );

  modport slave (
    input  o_start, o_cmd, o_addr, o_length, o_dat,
    output i_dat_req, i_dat_vld, i_dat, i_wr_end
  );
endinterface

// File: rtl/w5500_sock_rx.sv
// W5500 socket receive sequencer: polls Sn_RX_RSR, reads Sn_RX_RD, bursts the
// RX buffer out to a downstream FIFO, then advances Sn_RX_RD and issues RECV.
module w5500_sock_rx
  import w5500_pkg::*;
#(
  parameter int SOCK      = 0,
  parameter int MAX_CHUNK = 1024,
  parameter int POLL_GAP  = 5000
) (
  input  logic                   clk,
  input  logic                   rst,
  w5500_sock_rx_if.master        spi,
  input  logic                   i_en,
  input  logic [11:0]            i_fifo_free,
  output logic [7:0]             o_rx_dat,
  output logic                   o_rx_vld,
  output logic                   o_rx_last,
  output logic                   o_busy
);

  localparam logic [7:0]  CMD_REG_RD = mk_cmd(bsb_reg(SOCK), RWB_READ);
  localparam logic [7:0]  CMD_REG_WR = mk_cmd(bsb_reg(SOCK), RWB_WRITE);
  localparam logic [7:0]  CMD_RXB_RD = mk_cmd(bsb_rxb(SOCK), RWB_READ);
  localparam logic [15:0] MAX_N      = 16'(MAX_CHUNK);
  localparam int          GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_t             r_state;
  logic               r_issued;
  logic               r_start;
  logic [7:0]         r_cmd;
  logic [15:0]        r_addr;
  logic [15:0]        r_length;
  logic [7:0]         r_dat;
  logic [15:0]        r_shift;
  logic [15:0]        r_rsr_a;
  logic [15:0]        r_rsr_b;
  logic [15:0]        r_ptr;
  logic [15:0]        r_n;
  logic [15:0]        r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic [7:0]         r_rx_dat;
  logic               r_rx_vld;
  logic               r_rx_last;

  logic [15:0]        w_word;
  logic [15:0]        w_free;
  logic [15:0]        w_n;
  logic [15:0]        w_ptrn;
  logic               w_busy;
  logic               w_done;

  always_comb begin
    // A register read may deliver its last byte in the same cycle as i_wr_end.
    w_word = spi.i_dat_vld ? {r_shift[7:0], spi.i_dat} : r_shift;
    w_free = {4'd0, i_fifo_free};
    w_n    = r_rsr_b;
    if (MAX_N < w_n)  w_n = MAX_N;
    if (w_free < w_n) w_n = w_free;
    w_ptrn = r_ptr + r_n;
    w_busy = (r_state != ST_IDLE) && (r_state != ST_GAP);
    w_done = w_busy && r_issued && spi.i_wr_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_issued  <= 1'b0;
      r_start   <= 1'b0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_length  <= '0;
      r_dat     <= '0;
      r_shift   <= '0;
      r_rsr_a   <= '0;
      r_rsr_b   <= '0;
      r_ptr     <= '0;
      r_n       <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_rx_dat  <= '0;
      r_rx_vld  <= 1'b0;
      r_rx_last <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_rx_vld  <= 1'b0;
      r_rx_last <= 1'b0;

      if (spi.i_dat_vld && (r_state == ST_RSR1 || r_state == ST_RSR2 || r_state == ST_PTR))
        r_shift <= {r_shift[7:0], spi.i_dat};

      // cmd/addr/length were loaded on entry, so start follows one cycle later.
      if (w_busy && !r_issued) begin
        r_start  <= 1'b1;
        r_issued <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_en) begin
            r_state  <= ST_RSR1;
            r_issued <= 1'b0;
            r_cmd    <= CMD_REG_RD;
            r_addr   <= SN_RX_RSR;
            r_length <= 16'd2;
          end
        end

        ST_RSR1: begin
          if (w_done) begin
            r_rsr_a  <= w_word;
            r_state  <= ST_RSR2;
            r_issued <= 1'b0;
          end
        end

        ST_RSR2: begin
          if (w_done) begin
            r_rsr_b  <= w_word;
            r_issued <= 1'b0;
            if (w_word != r_rsr_a) begin
              r_state <= ST_RSR1;
            end else if (w_word == 16'd0) begin
              r_state <= ST_GAP;
              r_gap   <= '0;
            end else begin
              r_state <= ST_PTR;
              r_addr  <= SN_RX_RD;
            end
          end
        end

        ST_GAP: begin
          if (!i_en) begin
            r_state <= ST_IDLE;
          end else if (r_gap == GAP_LAST) begin
            r_state  <= ST_RSR1;
            r_issued <= 1'b0;
            r_cmd    <= CMD_REG_RD;
            r_addr   <= SN_RX_RSR;
            r_length <= 16'd2;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end

        ST_PTR: begin
          if (w_done) begin
            r_ptr    <= w_word;
            r_n      <= w_n;
            r_cnt    <= '0;
            r_issued <= 1'b0;
            if (w_n == 16'd0) begin
              r_state <= ST_GAP;
              r_gap   <= '0;
            end else begin
              r_state  <= ST_DATA;
              r_cmd    <= CMD_RXB_RD;
              r_addr   <= w_word;
              r_length <= w_n;
            end
          end
        end

        ST_DATA: begin
          if (spi.i_dat_vld) begin
            r_rx_vld  <= 1'b1;
            r_rx_dat  <= spi.i_dat;
            r_cnt     <= r_cnt + 16'd1;
            r_rx_last <= (16'(r_cnt + 16'd1) == r_n);
          end
          if (w_done) begin
            r_state  <= ST_WPTR;
            r_issued <= 1'b0;
            r_cmd    <= CMD_REG_WR;
            r_addr   <= SN_RX_RD;
            r_length <= 16'd2;
            r_dat    <= w_ptrn[15:8];
          end
        end

        ST_WPTR: begin
          if (w_done) begin
            r_state  <= ST_WCMD;
            r_issued <= 1'b0;
            r_addr   <= SN_CR;
            r_length <= 16'd1;
            r_dat    <= CR_RECV;
          end else if (spi.i_dat_req) begin
            r_dat <= w_ptrn[7:0];
          end
        end

        ST_WCMD: begin
          if (w_done) begin
            r_issued <= 1'b0;
            if (i_en) begin
              r_state  <= ST_RSR1;
              r_cmd    <= CMD_REG_RD;
              r_addr   <= SN_RX_RSR;
              r_length <= 16'd2;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spi.o_start  = r_start;
  assign spi.o_cmd    = r_cmd;
  assign spi.o_addr   = r_addr;
  assign spi.o_length = r_length;
  assign spi.o_dat    = r_dat;
  assign o_rx_dat     = r_rx_dat;
  assign o_rx_vld     = r_rx_vld;
  assign o_rx_last    = r_rx_last;
  assign o_busy       = w_busy;

endmodule

// File: tb/tb_w5500_sock_rx.sv
// Bench for w5500_sock_rx: a spi_drv/W5500 behavioural slave plus a
// transaction-level plan of what every receive pass must issue and stream.
module tb_w5500_sock_rx;
  import w5500_pkg::*;

  localparam int POLL_GAP  = 5000;
  localparam int MAX_CHUNK = 1024;
  localparam logic [7:0] C_REG_RD = 8'h08;
  localparam logic [7:0] C_REG_WR = 8'h0C;
  localparam logic [7:0] C_RXB_RD = 8'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic [11:0] i_fifo_free = 12'd2048;
  logic [7:0]  rx_dat;
  logic        rx_vld, rx_last, busy;

  always #5 clk = ~clk;

  w5500_sock_rx_if bus();

  w5500_sock_rx #(.SOCK(0), .MAX_CHUNK(MAX_CHUNK), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst(rst), .spi(bus), .i_en(i_en), .i_fifo_free(i_fifo_free),
    .o_rx_dat(rx_dat), .o_rx_vld(rx_vld), .o_rx_last(rx_last), .o_busy(busy)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] len;
    logic [7:0]  w0;
    logic [7:0]  w1;
  } txn_t;

  txn_t        q_exp[$];
  logic [15:0] q_rsr[$];
  logic [15:0] q_rd[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic exp_txn(input logic [7:0] c, input logic [15:0] a, input logic [15:0] l,
                         input logic [7:0] w0, input logic [7:0] w1);
    txn_t t;
    t.cmd = c; t.addr = a; t.len = l; t.w0 = w0; t.w1 = w1;
    q_exp.push_back(t);
  endtask

  // One poll plus, when stable and non-empty, the full receive pass it implies.
  task automatic plan_pass(input int unsigned a, input int unsigned b,
                           input logic [15:0] rd, input int unsigned free);
    int unsigned n;
    logic [15:0] ptrn;
    exp_txn(C_REG_RD, 16'h0026, 16'd2, 8'h00, 8'h00);
    exp_txn(C_REG_RD, 16'h0026, 16'd2, 8'h00, 8'h00);
    q_rsr.push_back(16'(a));
    q_rsr.push_back(16'(b));
    if (a != b || b == 0) return;
    exp_txn(C_REG_RD, 16'h0028, 16'd2, 8'h00, 8'h00);
    q_rd.push_back(rd);
    n = b;
    if (MAX_CHUNK < n) n = MAX_CHUNK;
    if (free < n) n = free;
    if (n == 0) return;
    ptrn = 16'(rd + n);
    exp_txn(C_RXB_RD, rd, 16'(n), 8'h00, 8'h00);
    exp_txn(C_REG_WR, 16'h0028, 16'd2, ptrn[15:8], ptrn[7:0]);
    exp_txn(C_REG_WR, 16'h0001, 16'd1, 8'h40, 8'h00);
  endtask

  // Slave model and compare state
  int          cyc = 0;
  int          wr_cyc = -100;
  int          m_phase = 0, m_len = 0, m_k = 0, m_wait = 0;
  txn_t        cur;
  logic [7:0]  l_cmd;
  logic [15:0] l_addr, l_len, m_word;
  logic [7:0]  prev_cmd = '0;
  logic [15:0] prev_addr = '0, prev_len = '0;
  bit          pend_vld = 0, pend_last = 0;
  logic [7:0]  pend_dat = '0;
  bit          in_data = 0;
  int          rx_count = 0, rx_obs = 0, rx_last_at = 0, data_cnt = 0, data_len = 0;
  logic [7:0]  w_rd0 = '0, w_rd1 = '0, w_cr = '0, w_cr_cmd = '0;
  logic [15:0] w_cr_addr = '0;
  int          last_gap = -1, low_len = 0;
  bit          seen_busy = 0, low_en_all = 1;

  initial begin
    logic [7:0] b;
    bus.i_dat_req = 1'b0;
    bus.i_dat_vld = 1'b0;
    bus.i_dat     = 8'h00;
    bus.i_wr_end  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i_dat_req = 1'b0;
      bus.i_dat_vld = 1'b0;
      bus.i_wr_end  = 1'b0;
      if (rst) begin
        m_phase = 0; pend_vld = 0; in_data = 0;
        seen_busy = 0; low_len = 0; low_en_all = 1;
      end else begin
        // Payload stream: exactly one cycle behind the slave's read strobe.
        chk("rx_vld", rx_vld, pend_vld);
        chk("rx_last", rx_last, pend_vld ? pend_last : 1'b0);
        if (pend_vld) chk("rx_dat", rx_dat, pend_dat);
        if (rx_vld) begin
          rx_obs++;
          if (rx_last) rx_last_at = rx_obs;
        end
        pend_vld = 0;

        if (busy) begin
          if (seen_busy && low_len > 0 && low_en_all) begin
            last_gap = low_len;
            chk("gap_len", low_len, POLL_GAP);
          end
          seen_busy = 1; low_len = 0; low_en_all = 1;
        end else begin
          low_len++;
          if (!i_en) low_en_all = 0;
        end

        if (m_phase != 0) begin
          chk("start_overlap", bus.o_start, 1'b0);
          chk("hold_stable", {bus.o_cmd, bus.o_addr, bus.o_length}, {l_cmd, l_addr, l_len});
        end

        case (m_phase)
          0: if (bus.o_start) begin
            chk("start_spacing", (cyc - wr_cyc) >= 2, 1'b1);
            chk("setup_before_start", {bus.o_cmd, bus.o_addr, bus.o_length},
                {prev_cmd, prev_addr, prev_len});
            if (q_exp.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_start actual=cmd %0h addr %0h len %0h required=no transaction",
                       bus.o_cmd, bus.o_addr, bus.o_length);
              cur.cmd = bus.o_cmd; cur.addr = bus.o_addr; cur.len = bus.o_length;
              cur.w0 = 8'h00; cur.w1 = 8'h00;
            end else begin
              cur = q_exp.pop_front();
              chk("txn_cmd", bus.o_cmd, cur.cmd);
              chk("txn_addr", bus.o_addr, cur.addr);
              chk("txn_len", bus.o_length, cur.len);
            end
            l_cmd = bus.o_cmd; l_addr = bus.o_addr; l_len = bus.o_length;
            m_len = int'(bus.o_length); m_k = 0; m_wait = $urandom_range(0, 2);
            m_word = 16'h0000;
            if (l_cmd == C_REG_RD && l_addr == 16'h0026) begin
              if (q_rsr.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsr_supply actual=empty required=planned value");
              end else m_word = q_rsr.pop_front();
            end else if (l_cmd == C_REG_RD && l_addr == 16'h0028) begin
              if (q_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_supply actual=empty required=planned value");
              end else m_word = q_rd.pop_front();
            end
            if (l_cmd == C_RXB_RD) begin
              in_data = 1; data_cnt++; data_len = m_len;
            end
            m_phase = (m_len == 0) ? 2 : 1;
          end
          1: begin
            if (m_wait > 0) m_wait--;
            else begin
              if (l_cmd[2]) begin
                bus.i_dat_req = 1'b1;
                chk("wr_byte", bus.o_dat, (m_k == 0) ? cur.w0 : cur.w1);
                if (l_addr == 16'h0028) begin
                  if (m_k == 0) w_rd0 = bus.o_dat; else w_rd1 = bus.o_dat;
                end else begin
                  w_cr = bus.o_dat; w_cr_cmd = l_cmd; w_cr_addr = l_addr;
                end
              end else begin
                if (l_cmd == C_RXB_RD) b = 8'($urandom);
                else b = (m_k == 0) ? m_word[15:8] : m_word[7:0];
                bus.i_dat_vld = 1'b1;
                bus.i_dat     = b;
                if (l_cmd == C_RXB_RD) begin
                  pend_vld = 1; pend_dat = b;
                  pend_last = (m_k == int'(cur.len) - 1);
                  rx_count++;
                end
              end
              m_k++;
              m_wait = $urandom_range(0, 2);
              if (m_k == m_len) m_phase = 2;
            end
          end
          default: begin
            if (m_wait > 0) m_wait--;
            else begin
              bus.i_wr_end = 1'b1;
              wr_cyc = cyc; m_phase = 0; in_data = 0;
            end
          end
        endcase
      end
      prev_cmd = bus.o_cmd; prev_addr = bus.o_addr; prev_len = bus.o_length;
    end
  end

  task automatic drain(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(q_exp.size() == 0 && m_phase == 0 && !busy) && t < budget);
    if (t >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", q_exp.size());
    end
  endtask

  task automatic end_case();
    i_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic wait_data(input int min_k, input int budget);
    int t;
    t = 0;
    while (!(in_data && m_k >= min_k) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) begin
      checks++; errors++;
      $display("FAIL data_wait actual=no burst required=burst in progress");
    end
  endtask

  initial begin
    int base_rx, base_obs, base_data;
    logic [15:0] rd;
    int unsigned a, free;

    repeat (3) @(negedge clk);
    chk("rst_start", bus.o_start, 1'b0);
    chk("rst_cmd", bus.o_cmd, 8'h00);
    chk("rst_addr", bus.o_addr, 16'h0000);
    chk("rst_len", bus.o_length, 16'h0000);
    chk("rst_dat", bus.o_dat, 8'h00);
    chk("rst_rx", {rx_vld, rx_last, rx_dat}, 10'h000);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_en", busy, 1'b0);

    // Case 1: empty socket polls, full gap between polls
    base_rx = rx_count;
    plan_pass(0, 0, 16'h0000, 2048);
    plan_pass(0, 0, 16'h0000, 2048);
    i_en = 1'b1;
    drain(20000);
    chk("c1_gap", last_gap, POLL_GAP);
    chk("c1_no_rx", rx_count - base_rx, 0);
    end_case();

    // Case 2: 16 bytes at 0x1FF8
    base_rx = rx_count; base_obs = rx_obs;
    plan_pass(16'h10, 16'h10, 16'h1FF8, 2048);
    plan_pass(0, 0, 16'h0000, 2048);
    i_en = 1'b1;
    drain(5000);
    chk("c2_rx_count", rx_count - base_rx, 16);
    chk("c2_last_at", rx_last_at - base_obs, 16);
    chk("c2_len", data_len, 16);
    chk("c2_wptr_hi", w_rd0, 8'h20);
    chk("c2_wptr_lo", w_rd1, 8'h08);
    chk("c2_recv", w_cr, 8'h40);
    chk("c2_recv_cmd", w_cr_cmd, 8'h0C);
    chk("c2_recv_addr", w_cr_addr, 16'h0001);
    end_case();

    // Case 3: unstable RSR forces a re-read
    base_rx = rx_count;
    plan_pass(16'h100, 16'h120, 16'h0000, 2048);
    plan_pass(16'h120, 16'h120, 16'h0400, 2048);
    plan_pass(0, 0, 16'h0000, 2048);
    i_en = 1'b1;
    drain(5000);
    chk("c3_len", data_len, 16'h120);
    chk("c3_rx_count", rx_count - base_rx, 16'h120);
    end_case();

    // Case 4: FIFO space limits the burst, then blocks it entirely
    i_fifo_free = 12'd200;
    plan_pass(3000, 3000, 16'h0100, 200);
    plan_pass(0, 0, 16'h0000, 200);
    i_en = 1'b1;
    drain(5000);
    chk("c4_len", data_len, 200);
    end_case();
    i_fifo_free = 12'd0;
    base_data = data_cnt;
    plan_pass(3000, 3000, 16'h0100, 0);
    i_en = 1'b1;
    drain(2000);
    chk("c4_no_data", data_cnt - base_data, 0);
    end_case();
    i_fifo_free = 12'd2048;

    // Case 5: read pointer wrap
    plan_pass(4, 4, 16'hFFFE, 2048);
    plan_pass(0, 0, 16'h0000, 2048);
    i_en = 1'b1;
    drain(2000);
    chk("c5_wptr_hi", w_rd0, 8'h00);
    chk("c5_wptr_lo", w_rd1, 8'h02);
    end_case();

    // Case 5b: enable drops mid-burst; pass still completes, then idles
    w_cr = 8'h00;
    plan_pass(4, 4, 16'hFFFE, 2048);
    i_en = 1'b1;
    wait_data(0, 2000);
    i_en = 1'b0;
    drain(2000);
    chk("c5b_wptr_lo", w_rd1, 8'h02);
    chk("c5b_recv", w_cr, 8'h40);
    repeat (20) @(negedge clk);
    chk("c5b_idle", busy, 1'b0);

    // Case 6: reset during a burst
    plan_pass(64, 64, 16'h0200, 2048);
    i_en = 1'b1;
    wait_data(3, 2000);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("c6_rst_start", bus.o_start, 1'b0);
    chk("c6_rst_bus", {bus.o_cmd, bus.o_addr, bus.o_length, bus.o_dat}, 48'h0);
    chk("c6_rst_rx", {rx_vld, rx_last, rx_dat}, 10'h000);
    chk("c6_rst_busy", busy, 1'b0);
    q_exp.delete(); q_rsr.delete(); q_rd.delete();
    plan_pass(0, 0, 16'h0000, 2048);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    drain(2000);
    end_case();

    // Randomised passes with a fixed FIFO level
    free = $urandom_range(100, 2048);
    i_fifo_free = 12'(free);
    base_rx = rx_count;
    for (int i = 0; i < 10; i++) begin
      a = (i == 4) ? $urandom_range(1100, 1500) : $urandom_range(1, 400);
      rd = 16'($urandom);
      if ($urandom_range(0, 4) == 0) plan_pass(a, a + 1, 16'h0000, free);
      plan_pass(a, a, rd, free);
    end
    plan_pass(0, 0, 16'h0000, free);
    i_en = 1'b1;
    drain(40000);
    end_case();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
